// File: rtl/spi_mult_master.sv
// -----------------------------------------------------------------------------
// spi_mult_master
//   SPI initiator (mode 0) for the serial multiplier peripheral. On an accepted
//   start it raises cs, shifts {a,b} out MSB first on mosi, lets sclk run for
//   GAP_BITS idle periods while the peripheral computes, then shifts the
//   2*WIDTH-bit product in from miso and presents it on result with a one-clock
//   done pulse.
//
// Ports
//   clk      in   system clock, all state changes on posedge
//   reset_n  in   asynchronous active-low reset
//   start    in   transfer request, only looked at in IDLE
//   a, b     in   operands, latched on the accepting edge
//   busy     out  high from the accepting edge until done
//   done     out  one-clock pulse when result is valid
//   result   out  product, held until the next done
//   sclk     out  serial clock, idles low
//   cs       out  active-high chip select
//   mosi     out  serial data to the peripheral, MSB first
//   miso     in   serial data from the peripheral, MSB first
// -----------------------------------------------------------------------------
module spi_mult_master #(
    parameter int WIDTH     = 4,
    parameter int SCLK_HALF = 10,
    parameter int GAP_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 sclk,
    output logic                 cs,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int PW      = 2 * WIDTH;
    localparam int CNT_MAX = (PW > GAP_BITS) ? PW : GAP_BITS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int DW      = $clog2(SCLK_HALF);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] CNT_PW   = CW'(PW);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_RECV = 2'd3
    } state_t;

    state_t          state_r;
    state_t          next_state_s;

    logic [DW-1:0]   div_r;
    logic [CW-1:0]   bit_cnt_r;
    // tx holds only the bits not yet on mosi; the MSB goes straight to mosi.
    logic [PW-2:0]   tx_r;
    logic [PW-1:0]   rx_r;
    logic [PW-1:0]   result_r;
    logic [PW-1:0]   ab_s;
    logic            busy_r;
    logic            done_r;
    logic            sclk_r;
    logic            cs_r;
    logic            mosi_r;

    logic            tick_s;
    logic            rise_s;
    logic            fall_s;
    logic            last_s;

    assign ab_s   = {a, b};
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign sclk   = sclk_r;
    assign cs     = cs_r;
    assign mosi   = mosi_r;

    // Divider terminal count and the sclk edge it produces this clock.
    always_comb begin
        tick_s = 1'b0;
        rise_s = 1'b0;
        fall_s = 1'b0;
        if ((state_r != ST_IDLE) && (div_r == DIV_LAST)) begin
            tick_s = 1'b1;
            rise_s = ~sclk_r;
            fall_s = sclk_r;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Phase end: falling edge after the last counted rise of the current phase.
    always_comb begin
        last_s = 1'b0;
        case (state_r)
            ST_SEND: last_s = fall_s && (bit_cnt_r == CNT_PW);
            ST_GAP:  last_s = fall_s && (bit_cnt_r == CNT_GAP);
            ST_RECV: last_s = fall_s && (bit_cnt_r == CNT_PW);
            default: last_s = 1'b0;
        endcase
    end

    // Next-state logic for the transfer sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (last_s) begin
                    next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (last_s) begin
                    next_state_s = ST_RECV;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_RECV: begin
                if (last_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RECV;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Divider, shift registers, bit counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r     <= {DW{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
            tx_r      <= {(PW-1){1'b0}};
            rx_r      <= {PW{1'b0}};
            result_r  <= {PW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sclk_r    <= 1'b0;
            cs_r      <= 1'b0;
            mosi_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;

            if (state_r == ST_IDLE) begin
                div_r     <= {DW{1'b0}};
                bit_cnt_r <= {CW{1'b0}};
                sclk_r    <= 1'b0;
            end else if (tick_s) begin
                div_r  <= {DW{1'b0}};
                sclk_r <= ~sclk_r;
            end else begin
                div_r <= div_r + {{(DW-1){1'b0}}, 1'b1};
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        tx_r   <= ab_s[PW-2:0];
                        rx_r   <= {PW{1'b0}};
                        mosi_r <= ab_s[PW-1];
                        cs_r   <= 1'b1;
                        busy_r <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (rise_s) begin
                        bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                    if (last_s) begin
                        mosi_r    <= 1'b0;
                        bit_cnt_r <= {CW{1'b0}};
                    end else if (fall_s) begin
                        mosi_r <= tx_r[PW-2];
                        tx_r   <= {tx_r[PW-3:0], 1'b0};
                    end
                end
                ST_GAP: begin
                    mosi_r <= 1'b0;
                    if (rise_s) begin
                        bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                    if (last_s) begin
                        bit_cnt_r <= {CW{1'b0}};
                    end
                end
                ST_RECV: begin
                    if (rise_s) begin
                        rx_r      <= {rx_r[PW-2:0], miso};
                        bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                    // The final fall closes the frame: sclk is forced low so it
                    // is never high while cs drops.
                    if (last_s) begin
                        result_r  <= rx_r;
                        done_r    <= 1'b1;
                        cs_r      <= 1'b0;
                        busy_r    <= 1'b0;
                        sclk_r    <= 1'b0;
                        div_r     <= {DW{1'b0}};
                        bit_cnt_r <= {CW{1'b0}};
                    end
                end
                default: begin
                    cs_r   <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mult_master.sv
// -----------------------------------------------------------------------------
// tb_spi_mult_master
//   Directed bench for spi_mult_master (WIDTH=4, SCLK_HALF=10, GAP_BITS=2).
//   A behavioural multiplier peripheral captures the first 8 mosi bits on sclk
//   rises and returns their 4x4 product MSB first, driven on falls.
// -----------------------------------------------------------------------------
module tb_spi_mult_master;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;

    int total;
    int bad;
    int done_cnt;
    bit mon_en;
    logic [7:0] cap;
    logic [7:0] prod;

    spi_mult_master #(.WIDTH(4), .SCLK_HALF(10), .GAP_BITS(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .sclk    (sclk),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Peripheral model: samples mosi on rises, returns product on falls.
    initial begin
        miso = 1'b0;
        cap  = 8'h00;
        prod = 8'h00;
        forever begin
            int rc;
            int fc;
            @(posedge cs);
            cap  = 8'h00;
            miso = 1'b0;
            rc   = 0;
            fc   = 0;
            while (cs) begin
                @(sclk or cs);
                if (cs && sclk) begin
                    rc++;
                    if (rc <= 8) cap = {cap[6:0], mosi};
                end else if (cs && !sclk) begin
                    fc++;
                    if (fc == 10) begin
                        prod = cap[7:4] * cap[3:0];
                        miso = prod[7];
                    end else if (fc > 10) begin
                        prod = {prod[6:0], 1'b0};
                        miso = prod[7];
                    end
                end
            end
            miso = 1'b0;
        end
    end

    // done pulse counter.
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    // sclk phase-length and idle-level monitor.
    initial begin
        int  len;
        bit  valid;
        logic prev_sclk;
        logic prev_cs;
        len = 0; valid = 1'b0; prev_sclk = 1'b0; prev_cs = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && !cs) chk("sclk_low_when_cs_low", {31'd0, sclk}, 32'd0);
            if ((sclk != prev_sclk) || (cs && !prev_cs)) begin
                if ((sclk != prev_sclk) && valid && mon_en)
                    chk("sclk_phase_len", len, 32'd10);
                len = 1;
                valid = cs;
            end else begin
                len++;
            end
            if (!cs || !mon_en) valid = 1'b0;
            prev_sclk = sclk;
            prev_cs   = cs;
        end
    end

    // Waits (bounded) for done; call #1 after the accepting edge.
    task automatic wait_done(input bit pulses, output int n, output int busy_cyc);
        bit seen;
        n = 0; busy_cyc = 0; seen = 1'b0;
        while (!seen && n < 500) begin
            @(negedge clk);
            if (pulses) start = ((n == 49) || (n == 199)) ? 1'b1 : 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cyc++;
                @(posedge clk);
                n++;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic run_txn(input logic [3:0] ta, input logic [3:0] tb_v,
                           input logic [7:0] exp_res, input bit pulses);
        int n;
        int bc;
        int dc0;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ta; b = ~tb_v;
        dc0 = done_cnt;
        chk("accept_cs", {31'd0, cs}, 32'd1);
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_sclk", {31'd0, sclk}, 32'd0);
        chk("accept_mosi", {31'd0, mosi}, {31'd0, ta[3]});
        wait_done(pulses, n, bc);
        start = 1'b0;
        chk("latency", n, 32'd360);
        chk("busy_cycles", bc, 32'd360);
        chk("result", {24'd0, result}, {24'd0, exp_res});
        chk("mosi_bits", {24'd0, cap}, {24'd0, ta, tb_v});
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_cs", {31'd0, cs}, 32'd0);
        @(negedge clk);
        chk("done_width", {31'd0, done}, 32'd0);
        chk("done_count", done_cnt - dc0, 32'd1);
        chk("idle_cs", {31'd0, cs}, 32'd0);
        chk("result_held", {24'd0, result}, {24'd0, exp_res});
    endtask

    initial begin
        int n;
        int bc;
        int dc0;
        total = 0; bad = 0; done_cnt = 0; mon_en = 1'b1;
        reset_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_cs", {31'd0, cs}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(4'h3, 4'h5, 8'h0F, 1'b0);
        run_txn(4'hF, 4'hF, 8'hE1, 1'b0);
        run_txn(4'h9, 4'h7, 8'h3F, 1'b1);

        // Reset in the middle of SEND.
        @(negedge clk);
        a = 4'h6; b = 4'h6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dc0 = done_cnt;
        repeat (100) @(posedge clk);
        mon_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("abort_cs", {31'd0, cs}, 32'd0);
        chk("abort_sclk", {31'd0, sclk}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (400) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 32'd0);
        chk("abort_result_kept", {24'd0, result}, 32'd0);

        run_txn(4'h2, 4'h6, 8'h0C, 1'b0);

        // start held high: back-to-back transfers.
        @(negedge clk);
        a = 4'h1; b = 4'h2; start = 1'b1;
        @(posedge clk);
        #1 a = 4'hA; b = 4'h3;
        wait_done(1'b0, n, bc);
        chk("b2b_lat1", n, 32'd360);
        chk("b2b_res1", {24'd0, result}, 32'h02);
        chk("b2b_gap_cs", {31'd0, cs}, 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_restart_cs", {31'd0, cs}, 32'd1);
        chk("b2b_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(1'b0, n, bc);
        chk("b2b_lat2", n, 32'd360);
        chk("b2b_res2", {24'd0, result}, 32'h1E);
        chk("b2b_mosi2", {24'd0, cap}, 32'hA3);
        repeat (3) @(negedge clk);
        chk("b2b_stop", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
